// File: rtl/servant_uart_rx.sv
// 8N1 UART receiver for the servant q line, with a small ready/valid byte FIFO.
// The line is synchronised, start bits are qualified at mid-bit, and data and
// stop bits are sampled at bit centres. Complete bytes are pushed into the FIFO.

module servant_uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 32,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic       wb_clk,
  input  logic       wb_rst_n,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_frame_err,
  output logic       o_overflow,
  output logic       o_busy
);

  localparam int unsigned PtrW    = $clog2(FIFO_DEPTH);
  localparam logic [15:0] FullCnt = 16'(CLKS_PER_BIT - 1);
  // The half-bit delay rounds down for odd CLKS_PER_BIT.
  localparam logic [15:0] HalfCnt = 16'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

  state_e      state_q;
  logic [15:0] clk_cnt_q;
  logic [2:0]  bit_cnt_q;
  logic [7:0]  shift_q;
  logic        frame_err_q;
  logic        rx_meta_q, rx_s;

  logic [7:0]  mem [FIFO_DEPTH];
  logic [PtrW:0] wr_ptr_q, rd_ptr_q;
  logic        overflow_q;
  logic        empty, full, pop, push, push_req;

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s      <= 1'b1;
    end else begin
      rx_meta_q <= i_rx;
      rx_s      <= rx_meta_q;
    end
  end

  // Receive FSM: start qualification, data shift, stop check and break hold.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q     <= StIdle;
      clk_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (!rx_s) begin
            state_q   <= StStart;
            clk_cnt_q <= HalfCnt;
          end
        end
        StStart: begin
          if (clk_cnt_q == 16'd0) begin
            if (!rx_s) begin
              state_q   <= StData;
              clk_cnt_q <= FullCnt;
              bit_cnt_q <= 3'd0;
            end else begin
              // Glitch shorter than half a bit: drop it silently.
              state_q <= StIdle;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q - 16'd1;
          end
        end
        StData: begin
          if (clk_cnt_q == 16'd0) begin
            shift_q[bit_cnt_q] <= rx_s;
            clk_cnt_q          <= FullCnt;
            if (bit_cnt_q == 3'd7) begin
              state_q <= StStop;
            end else begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q - 16'd1;
          end
        end
        StStop: begin
          if (clk_cnt_q == 16'd0) begin
            if (rx_s) begin
              state_q <= StIdle;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= StBreak;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q - 16'd1;
          end
        end
        StBreak: begin
          // A held-low line reports one error, then waits for idle.
          if (rx_s) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign push_req = (state_q == StStop) && (clk_cnt_q == 16'd0) && rx_s;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                 (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
  assign pop   = !empty && i_ready;
  // A pop in the same cycle frees the slot the push lands in.
  assign push  = push_req && (!full || pop);

  // FIFO storage; the head is read combinationally, so it is stable until popped.
  always_ff @(posedge wb_clk) begin
    if (push) mem[wr_ptr_q[PtrW-1:0]] <= shift_q;
  end

  // FIFO pointers and the sticky overflow flag.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_req && !push) overflow_q <= 1'b1;
    end
  end

  assign o_valid     = !empty;
  assign o_data      = empty ? 8'h00 : mem[rd_ptr_q[PtrW-1:0]];
  assign o_frame_err = frame_err_q;
  assign o_overflow  = overflow_q;
  assign o_busy      = (state_q != StIdle);

endmodule

// File: tb/tb_servant_uart_rx.sv
// Directed bench for servant_uart_rx at CLKS_PER_BIT=8, FIFO_DEPTH=4.

module tb_servant_uart_rx;

  localparam int unsigned Cpb = 8;

  logic       wb_clk = 1'b0;
  logic       wb_rst_n = 1'b0;
  logic       i_rx = 1'b1;
  logic       i_ready = 1'b1;
  logic [7:0] o_data;
  logic       o_valid, o_frame_err, o_overflow, o_busy;

  int checks = 0;
  int errors = 0;

  // Monitor state: popped bytes and frame-error high cycles.
  logic [7:0] pops[$];
  int         ferr_cnt = 0;

  // Per-frame observations from send_frame.
  int         first_valid_edge;
  logic [7:0] first_data;
  int         valid_cycles;

  servant_uart_rx #(
    .CLKS_PER_BIT(Cpb),
    .FIFO_DEPTH  (4)
  ) dut (
    .wb_clk     (wb_clk),
    .wb_rst_n   (wb_rst_n),
    .i_rx       (i_rx),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_frame_err(o_frame_err),
    .o_overflow (o_overflow),
    .o_busy     (o_busy)
  );

  always #5 wb_clk = ~wb_clk;

  always @(negedge wb_clk) begin
    if (wb_rst_n && o_valid && i_ready) pops.push_back(o_data);
    if (wb_rst_n && o_frame_err) ferr_cnt++;
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge wb_clk);
      #1;
    end
  endtask

  // Drives one 10-bit frame; edge 0 is where the start bit begins.
  // ready_edge > 0 raises i_ready after that edge.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int ready_edge);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    @(posedge wb_clk);
    #1;
    i_rx = bits[0];
    first_valid_edge = -1;
    first_data = 8'h00;
    valid_cycles = 0;
    for (int k = 1; k <= 80; k++) begin
      @(posedge wb_clk);
      #1;
      if (k == ready_edge) i_ready = 1'b1;
      if (o_valid) begin
        if (first_valid_edge < 0) begin
          first_valid_edge = k;
          first_data = o_data;
        end
        valid_cycles++;
      end
      if ((k % 8 == 0) && (k < 80)) i_rx = bits[k/8];
    end
  endtask

  task automatic check_pops(input string name, input logic [7:0] exp[$]);
    checks++;
    if (pops.size() != exp.size()) begin
      errors++;
      $display("FAIL %s: pop count %0d, required %0d", name, pops.size(), exp.size());
    end else begin
      for (int i = 0; i < exp.size(); i++) begin
        checks++;
        if (pops[i] !== exp[i]) begin
          errors++;
          $display("FAIL %s[%0d]: got %02h, required %02h", name, i, pops[i], exp[i]);
        end
      end
    end
    pops.delete();
  endtask

  task automatic check_outs_zero(input string name);
    checks++;
    if ({o_valid, o_data, o_frame_err, o_overflow, o_busy} !== 12'h000) begin
      errors++;
      $display("FAIL %s: valid=%b data=%02h ferr=%b ovf=%b busy=%b, required all 0",
               name, o_valid, o_data, o_frame_err, o_overflow, o_busy);
    end
  endtask

  task automatic test_reset;
    #2;
    check_outs_zero("reset_asserted");
    tick(2);
    wb_rst_n = 1'b1;
    tick(5);
    check_outs_zero("reset_released");
  endtask

  task automatic test_single_frame;
    int f0;
    f0 = ferr_cnt;
    send_frame(8'h55, 1'b1, 0);
    checks++;
    if (first_valid_edge != 79) begin
      errors++;
      $display("FAIL single_latency: valid at edge %0d, required 79", first_valid_edge);
    end
    checks++;
    if (first_data !== 8'h55) begin
      errors++;
      $display("FAIL single_data: got %02h, required 55", first_data);
    end
    checks++;
    if (valid_cycles != 1) begin
      errors++;
      $display("FAIL single_pulse: valid for %0d cycles, required 1", valid_cycles);
    end
    checks++;
    if (ferr_cnt != f0) begin
      errors++;
      $display("FAIL single_ferr: %0d error cycles, required 0", ferr_cnt - f0);
    end
    tick(4);
    check_pops("single_pops", '{8'h55});
  endtask

  task automatic test_glitch;
    int f0;
    int n;
    f0 = ferr_cnt;
    i_rx = 1'b0;
    tick(3);
    i_rx = 1'b1;
    checks++;
    if (o_busy !== 1'b1) begin
      errors++;
      $display("FAIL glitch_busy: busy=%b, required 1", o_busy);
    end
    n = 0;
    while (o_busy && n < 8) begin
      tick(1);
      n++;
    end
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("FAIL glitch_idle: busy=%b after %0d cycles, required 0", o_busy, n);
    end
    tick(10);
    checks++;
    if (ferr_cnt != f0) begin
      errors++;
      $display("FAIL glitch_ferr: %0d error cycles, required 0", ferr_cnt - f0);
    end
    check_pops("glitch_pops", '{});
  endtask

  task automatic test_frame_error;
    int f0;
    f0 = ferr_cnt;
    send_frame(8'hA3, 1'b0, 0);
    tick(32);
    checks++;
    if (o_busy !== 1'b1) begin
      errors++;
      $display("FAIL break_busy: busy=%b, required 1", o_busy);
    end
    i_rx = 1'b1;
    tick(16);
    checks++;
    if (ferr_cnt != f0 + 1) begin
      errors++;
      $display("FAIL ferr_single: %0d error cycles, required 1", ferr_cnt - f0);
    end
    check_pops("ferr_pops", '{});
    send_frame(8'h3C, 1'b1, 0);
    tick(4);
    check_pops("ferr_next", '{8'h3C});
  endtask

  task automatic test_overflow;
    i_ready = 1'b0;
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 0);
    tick(3);
    checks++;
    if (o_overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_flag: overflow=%b, required 1", o_overflow);
    end
    checks++;
    if (o_valid !== 1'b1 || o_data !== 8'h01) begin
      errors++;
      $display("FAIL ovf_head: valid=%b data=%02h, required 1/01", o_valid, o_data);
    end
    tick(5);
    checks++;
    if (o_data !== 8'h01) begin
      errors++;
      $display("FAIL ovf_stable: data=%02h, required 01", o_data);
    end
    i_ready = 1'b1;
    tick(8);
    check_pops("ovf_pops", '{8'h01, 8'h02, 8'h03, 8'h04});
    checks++;
    if (o_valid !== 1'b0 || o_overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_after: valid=%b overflow=%b, required 0/1", o_valid, o_overflow);
    end
  endtask

  task automatic test_reset_mid_frame;
    @(posedge wb_clk);
    #1;
    i_rx = 1'b0;
    tick(8);
    i_rx = 1'b1;
    tick(32);
    #1;
    wb_rst_n = 1'b0;
    #1;
    check_outs_zero("midframe_reset");
    tick(2);
    wb_rst_n = 1'b1;
    tick(60);
    check_pops("midframe_nothing", '{});
    send_frame(8'h12, 1'b1, 0);
    tick(4);
    check_pops("midframe_next", '{8'h12});
  endtask

  task automatic test_full_push_pop;
    i_ready = 1'b0;
    send_frame(8'h10, 1'b1, 0);
    send_frame(8'h20, 1'b1, 0);
    send_frame(8'h30, 1'b1, 0);
    send_frame(8'h40, 1'b1, 0);
    send_frame(8'h77, 1'b1, 78);
    tick(8);
    checks++;
    if (o_overflow !== 1'b0) begin
      errors++;
      $display("FAIL full_pushpop_ovf: overflow=%b, required 0", o_overflow);
    end
    check_pops("full_pushpop", '{8'h10, 8'h20, 8'h30, 8'h40, 8'h77});
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_glitch();
    test_frame_error();
    test_overflow();
    test_reset_mid_frame();
    test_full_push_pop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
